// File: rtl/sound_pkg.sv
// Shared types for the sound player: event codes, FSM states and event priority.
// The SOUND_SWEEP_EN build option (descending pitch on EVT_BAD) lives in tone_divider.
package sound_pkg;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_MOVE = 2'd1,
    EVT_GOOD = 2'd2,
    EVT_BAD  = 2'd3
  } SOUND_EVT;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_PLAY = 1'b1
  } PLAY_STATE;

  function automatic logic [1:0] evt_prio(input SOUND_EVT e);
    case (e)
      EVT_BAD:  return 2'd3;
      EVT_GOOD: return 2'd2;
      EVT_MOVE: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sound_player_if.sv
// Sound request bus: request strobe with qualifiers in, tone and status out.
// Requests are plain strobes sampled every posedge; there is no ready, a request is either taken or dropped.
interface sound_player_if;
  import sound_pkg::*;

  logic      playSound;
  logic      goodColl;
  logic      badColl;
  logic      speaker;
  logic      busy;
  SOUND_EVT  evt_o;
  PLAY_STATE state_dbg;

  modport master (
    output playSound, goodColl, badColl,
    input  speaker, busy, evt_o, state_dbg
  );

  modport slave (
    input  playSound, goodColl, badColl,
    output speaker, busy, evt_o, state_dbg
  );
endinterface

// File: rtl/tone_divider.sv
// Square-wave generator: load starts a fresh half-period with wave=1.
// With SOUND_SWEEP_EN defined, a swept load stretches the half-period after every toggle.
module tone_divider #(
  parameter int CNT_W = 24
`ifdef SOUND_SWEEP_EN
  , parameter int SWEEP_STEP = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
`ifdef SOUND_SWEEP_EN
  input  logic             sweep,
`endif
  input  logic [CNT_W-1:0] half_in,
  output logic             wave
);

  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] half_q;
  logic             at_end;

  assign at_end = (half_cnt == half_q - CNT_W'(1));

`ifdef SOUND_SWEEP_EN
  logic           sweeping;
  logic [CNT_W:0] half_sum;
  logic [CNT_W-1:0] half_grown;

  // Saturate instead of wrapping so a long note never jumps back to a high pitch.
  assign half_sum   = {1'b0, half_q} + (CNT_W+1)'(SWEEP_STEP);
  assign half_grown = half_sum[CNT_W] ? '1 : half_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sweeping <= 1'b0;
    end else if (load) begin
      sweeping <= sweep;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= '0;
      half_q   <= '0;
      wave     <= 1'b0;
    end else if (load) begin
      half_cnt <= '0;
      half_q   <= half_in;
      wave     <= 1'b1;
    end else if (at_end) begin
      half_cnt <= '0;
      wave     <= ~wave;
`ifdef SOUND_SWEEP_EN
      if (sweeping) half_q <= half_grown;
`endif
    end else begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sound_player.sv
// Sound request consumer: decodes event priority, runs the note FSM and duration counter.
// Build option SOUND_SWEEP_EN enables the descending sweep on EVT_BAD notes.
module sound_player
  import sound_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int MOVE_HALF = 10000,
  parameter int GOOD_HALF = 5000,
  parameter int BAD_HALF  = 20000,
  parameter int MOVE_DUR  = 500000,
  parameter int GOOD_DUR  = 2000000,
  parameter int BAD_DUR   = 4000000
`ifdef SOUND_SWEEP_EN
  , parameter int SWEEP_STEP = 64
`endif
) (
  input  logic           clk,
  input  logic           rst,
  sound_player_if.slave  bus
);

  PLAY_STATE        state, state_next;
  SOUND_EVT         evt_q, evt_next, req_evt;
  logic [CNT_W-1:0] dur_cnt, dur_next, cur_dur, req_half;
  logic             busy_q, accept, last, div_rst, wave;

  always_comb begin
    req_evt    = EVT_NONE;
    req_half   = CNT_W'(MOVE_HALF);
    cur_dur    = CNT_W'(MOVE_DUR);
    accept     = 1'b0;
    last       = 1'b0;
    state_next = state;
    evt_next   = evt_q;
    dur_next   = dur_cnt;

    if (bus.badColl)       req_evt = EVT_BAD;
    else if (bus.goodColl) req_evt = EVT_GOOD;
    else                   req_evt = EVT_MOVE;

    case (req_evt)
      EVT_BAD:  req_half = CNT_W'(BAD_HALF);
      EVT_GOOD: req_half = CNT_W'(GOOD_HALF);
      default:  req_half = CNT_W'(MOVE_HALF);
    endcase

    case (evt_q)
      EVT_BAD:  cur_dur = CNT_W'(BAD_DUR);
      EVT_GOOD: cur_dur = CNT_W'(GOOD_DUR);
      default:  cur_dur = CNT_W'(MOVE_DUR);
    endcase

    // Equal priority retriggers, so a repeat on the final cycle leaves no idle gap.
    accept = bus.playSound &&
             ((state == P_IDLE) || (evt_prio(req_evt) >= evt_prio(evt_q)));
    last   = (state == P_PLAY) && (dur_cnt == cur_dur - CNT_W'(1));

    if (accept) begin
      state_next = P_PLAY;
      evt_next   = req_evt;
      dur_next   = '0;
    end else if (last) begin
      state_next = P_IDLE;
      evt_next   = EVT_NONE;
      dur_next   = '0;
    end else if (state == P_PLAY) begin
      dur_next   = dur_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= P_IDLE;
      evt_q   <= EVT_NONE;
      dur_cnt <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      evt_q   <= evt_next;
      dur_cnt <= dur_next;
      busy_q  <= (state_next == P_PLAY);
    end
  end

  // Holding the divider in reset while idle keeps the speaker low between notes.
  assign div_rst = rst || (state_next == P_IDLE);

  tone_divider #(
    .CNT_W      (CNT_W)
`ifdef SOUND_SWEEP_EN
    , .SWEEP_STEP (SWEEP_STEP)
`endif
  ) u_tone (
    .clk     (clk),
    .rst     (div_rst),
    .load    (accept),
`ifdef SOUND_SWEEP_EN
    .sweep   (req_evt == EVT_BAD),
`endif
    .half_in (req_half),
    .wave    (wave)
  );

  assign bus.speaker   = wave;
  assign bus.busy      = busy_q;
  assign bus.evt_o     = evt_q;
  assign bus.state_dbg = state;

endmodule
